global_pool_nxn: RTL and testbench

//  Parametrised global pooling stage closing the CNN feature-extractor chain.

---
 rtl/global_pool_nxn.sv | 107 ++++++++++
 tb/tb_global_pool_nxn.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/global_pool_nxn.sv
// Global pooling over CH channels of D x D signed pixels, channel-major.
// Emits one average or maximum per channel; the mode is latched on each frame's first pixel.
module global_pool_nxn #(
   parameter int data_width = 32,
   parameter int D          = 8,
   parameter int CH         = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 valid_in,
   input  logic [data_width-1:0]                pxl_in,
   input  logic                                 mode,
   output logic [data_width-1:0]                pxl_out,
   output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] ch_out,
   output logic                                 valid_out,
   output logic                                 frame_done
);

   localparam int SH = 2 * $clog2(D);
   localparam int PIX = D * D;
   localparam int AW = data_width + SH;
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [SH-1:0] PIX_LAST = SH'(PIX - 1);
   localparam logic [CW-1:0] CH_LAST = CW'(CH - 1);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                 state_q;
   logic                   mode_q;
   logic [SH-1:0]          pix_cnt_q;
   logic [CW-1:0]          ch_cnt_q;
   logic signed [AW-1:0]   acc_q;
   logic [data_width-1:0]  pxl_out_q;
   logic [CW-1:0]          ch_out_q;
   logic                   valid_out_q;
   logic                   frame_done_q;

   logic                   mode_eff;
   logic                   first_pix;
   logic                   last_pix;
   logic                   ch_last;
   logic signed [AW-1:0]   pxl_ext;
   logic signed [AW-1:0]   sum_d;
   logic signed [AW-1:0]   max_d;
   logic signed [AW-1:0]   acc_d;
   logic [data_width-1:0]  res_d;

   always_comb begin
      // The pixel that opens a frame carries the mode for the whole frame.
      mode_eff  = (state_q == IDLE) ? mode : mode_q;
      first_pix = (pix_cnt_q == '0);
      last_pix  = (pix_cnt_q == PIX_LAST);
      ch_last   = (ch_cnt_q == CH_LAST);
      pxl_ext   = {{SH{pxl_in[data_width-1]}}, pxl_in};
      sum_d     = acc_q + pxl_ext;
      max_d     = (first_pix || (pxl_ext > acc_q)) ? pxl_ext : acc_q;
      acc_d     = mode_eff ? max_d : sum_d;
      // Dropping the low SH bits of the signed sum is a floor division by D*D.
      res_d     = mode_eff ? max_d[data_width-1:0] : sum_d[SH +: data_width];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         mode_q       <= 1'b0;
         pix_cnt_q    <= '0;
         ch_cnt_q     <= '0;
         acc_q        <= '0;
         pxl_out_q    <= '0;
         ch_out_q     <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
         if (valid_in) begin
            if (state_q == IDLE) begin
               mode_q  <= mode;
               state_q <= ACCUM;
            end
            if (last_pix) begin
               pxl_out_q   <= res_d;
               ch_out_q    <= ch_cnt_q;
               valid_out_q <= 1'b1;
               acc_q       <= '0;
               pix_cnt_q   <= '0;
               if (ch_last) begin
                  ch_cnt_q     <= '0;
                  frame_done_q <= 1'b1;
                  state_q      <= IDLE;
               end else begin
                  ch_cnt_q <= ch_cnt_q + CW'(1);
               end
            end else begin
               acc_q     <= acc_d;
               pix_cnt_q <= pix_cnt_q + SH'(1);
            end
         end
      end
   end

   assign pxl_out    = pxl_out_q;
   assign ch_out     = ch_out_q;
   assign valid_out  = valid_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_global_pool_nxn.sv
// Bench for global_pool_nxn: five instances of different geometry share one stimulus bus;
// directed vectors from a table plus randomized frames checked against a plain arithmetic model.
module tb_global_pool_nxn;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  vin;
   logic [31:0] pxl;
   logic        mode;

   logic [31:0] po [5];
   logic [1:0]  co [5];
   logic        vo [5];
   logic        fd [5];
   logic        c_a, c_b, c_d;
   logic [1:0]  c_c, c_e;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   global_pool_nxn #(.data_width(32), .D(8), .CH(1)) u0 (
      .clk(clk), .reset(rst), .valid_in(vin[0]), .pxl_in(pxl), .mode(mode),
      .pxl_out(po[0]), .ch_out(c_a), .valid_out(vo[0]), .frame_done(fd[0]));
   global_pool_nxn #(.data_width(32), .D(4), .CH(2)) u1 (
      .clk(clk), .reset(rst), .valid_in(vin[1]), .pxl_in(pxl), .mode(mode),
      .pxl_out(po[1]), .ch_out(c_b), .valid_out(vo[1]), .frame_done(fd[1]));
   global_pool_nxn #(.data_width(32), .D(2), .CH(3)) u2 (
      .clk(clk), .reset(rst), .valid_in(vin[2]), .pxl_in(pxl), .mode(mode),
      .pxl_out(po[2]), .ch_out(c_c), .valid_out(vo[2]), .frame_done(fd[2]));
   global_pool_nxn #(.data_width(32), .D(4), .CH(1)) u3 (
      .clk(clk), .reset(rst), .valid_in(vin[3]), .pxl_in(pxl), .mode(mode),
      .pxl_out(po[3]), .ch_out(c_d), .valid_out(vo[3]), .frame_done(fd[3]));
   global_pool_nxn #(.data_width(32), .D(8), .CH(4)) u4 (
      .clk(clk), .reset(rst), .valid_in(vin[4]), .pxl_in(pxl), .mode(mode),
      .pxl_out(po[4]), .ch_out(c_e), .valid_out(vo[4]), .frame_done(fd[4]));

   always_comb begin
      co[0] = {1'b0, c_a};
      co[1] = {1'b0, c_b};
      co[2] = c_c;
      co[3] = {1'b0, c_d};
      co[4] = c_e;
   end

   typedef struct {
      int                 dut;
      logic signed [31:0] val;
      int                 ch;
      bit                 fd;
      int                 cyc;
   } pulse_t;

   pulse_t cap[$];
   pulse_t expq[$];

   always @(negedge clk) begin
      for (int i = 0; i < 5; i++)
         if (vo[i] === 1'b1) cap.push_back('{i, po[i], int'(co[i]), fd[i], cyc});
   end

   typedef struct {
      int                 dut;
      int                 npix;
      bit                 mode;
      bit                 expl;
      logic signed [31:0] p [4];
      logic signed [31:0] base;
      int                 step;
      logic signed [31:0] e_val;
      int                 e_ch;
      bit                 e_fd;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic idle();
      vin = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int dut, input logic signed [31:0] v, input bit m);
      vin  = 5'b1 << dut;
      pxl  = v;
      mode = m;
      @(posedge clk);
      #1;
      vin = '0;
   endtask

   // Reference: mean rounded toward minus infinity, or the plain maximum.
   function automatic longint golden(input bit m, input longint px[$]);
      longint s, r, n;
      n = px.size();
      if (m) begin
         r = px[0];
         foreach (px[i]) if (px[i] > r) r = px[i];
         return r;
      end
      s = 0;
      foreach (px[i]) s += px[i];
      r = s / n;
      if (s < 0 && (s % n) != 0) r = r - 1;
      return r;
   endfunction

   // One frame of random pixels; gaps and mid-frame mode flips optional.
   task automatic send_frame(input int dut, input int npix, input int nch, input bit m,
                             input int gapmax, input bit toggle);
      longint px[$];
      logic signed [31:0] v;
      bit md;
      for (int c = 0; c < nch; c++) begin
         px.delete();
         for (int i = 0; i < npix; i++) begin
            if (gapmax > 0) begin
               repeat ($urandom_range(0, gapmax)) begin
                  mode = toggle ? 1'($urandom()) : m;
                  idle();
               end
            end
            v  = $urandom();
            md = (toggle && !(c == 0 && i == 0)) ? ~m : m;
            px.push_back(longint'(v));
            drive(dut, v, md);
         end
         expq.push_back('{dut, 32'(golden(m, px)), c, (c == nch - 1), 0});
      end
   endtask

   task automatic compare_caps(input string tag);
      int n;
      chk({tag, "_pulses"}, cap.size(), expq.size());
      n = (cap.size() < expq.size()) ? cap.size() : expq.size();
      for (int k = 0; k < n; k++) begin
         chk($sformatf("%s_val%0d", tag, k), longint'(cap[k].val), longint'(expq[k].val));
         chk($sformatf("%s_ch%0d", tag, k), cap[k].ch, expq[k].ch);
         chk($sformatf("%s_fd%0d", tag, k), cap[k].fd, expq[k].fd);
         chk($sformatf("%s_dut%0d", tag, k), cap[k].dut, expq[k].dut);
      end
   endtask

   initial begin
      logic signed [31:0] v;
      bit m;

      tbl[0] = '{0, 64, 1'b0, 1'b0, '{0, 0, 0, 0}, 5, 0, 5, 0, 1'b1};
      tbl[1] = '{1, 16, 1'b0, 1'b0, '{0, 0, 0, 0}, 0, 1, 7, 0, 1'b0};
      tbl[2] = '{1, 16, 1'b0, 1'b0, '{0, 0, 0, 0}, -3, 0, -3, 1, 1'b1};
      tbl[3] = '{2, 4, 1'b1, 1'b1, '{-9, -2, -7, -4}, 0, 0, -2, 0, 1'b0};
      tbl[4] = '{2, 4, 1'b1, 1'b1, '{1, 8, 3, 8}, 0, 0, 8, 1, 1'b0};
      tbl[5] = '{2, 4, 1'b1, 1'b1, '{32'sh7FFFFFFF, 0, 0, 0}, 0, 0, 32'sh7FFFFFFF, 2, 1'b1};

      rst = 1'b1; vin = '0; pxl = '0; mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rst_pxl%0d", i), po[i], 0);
         chk($sformatf("rst_ch%0d", i), co[i], 0);
         chk($sformatf("rst_vo%0d", i), vo[i], 0);
         chk($sformatf("rst_fd%0d", i), fd[i], 0);
      end
      rst = 1'b0;
      idle();

      // Directed channels from the table, one pulse each.
      for (int r = 0; r < 6; r++) begin
         cap.delete();
         for (int i = 0; i < tbl[r].npix; i++) begin
            if (tbl[r].expl) v = tbl[r].p[i];
            else v = tbl[r].base + tbl[r].step * i;
            drive(tbl[r].dut, v, tbl[r].mode);
         end
         idle(); idle();
         chk($sformatf("tbl%0d_pulses", r), cap.size(), 1);
         if (cap.size() >= 1) begin
            chk($sformatf("tbl%0d_val", r), longint'(cap[0].val), longint'(tbl[r].e_val));
            chk($sformatf("tbl%0d_ch", r), cap[0].ch, tbl[r].e_ch);
            chk($sformatf("tbl%0d_fd", r), cap[0].fd, tbl[r].e_fd);
         end
      end
      repeat (3) idle();
      chk("hold_pxl", po[2], 32'h7FFFFFFF);
      chk("hold_ch", co[2], 2);
      chk("hold_vo", vo[2], 0);

      // Random gaps with the mode flipped after the first pixel.
      for (int rep = 0; rep < 4; rep++) begin
         cap.delete(); expq.delete();
         send_frame(3, 16, 1, 1'(rep % 2), 3, 1'b1);
         idle(); idle();
         compare_caps($sformatf("gap%0d", rep));
      end

      // Reset in the middle of channel 0 discards the partial frame.
      cap.delete(); expq.delete();
      for (int i = 0; i < 10; i++) drive(1, $urandom(), 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_pxl", po[1], 0);
      chk("arst_vo", vo[1], 0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle();
      chk("abort_pulses", cap.size(), 0);
      m = 1'($urandom());
      send_frame(1, 16, 2, m, 0, 1'b0);
      idle(); idle();
      compare_caps("after_rst");

      // Two frames back-to-back with valid held high: average then max.
      cap.delete(); expq.delete();
      send_frame(4, 64, 4, 1'b0, 0, 1'b0);
      send_frame(4, 64, 4, 1'b1, 0, 1'b0);
      idle(); idle();
      compare_caps("b2b");
      for (int k = 1; k < cap.size(); k++)
         chk($sformatf("b2b_gap%0d", k), cap[k].cyc - cap[k-1].cyc, 64);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
